// File: rtl/sqr_axil_slave.sv
// AXI4-Lite register block in front of a shift-and-add squaring unit.
// Software loads OPERAND, pulses START, then polls STATUS or waits on irq before reading RESULT.
module sqr_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_OP_WIDTH         = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            irq
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
  localparam int ACC_W = 2 * C_OP_WIDTH;
  localparam int CNT_W = $clog2(C_OP_WIDTH) + 1;

  localparam logic [1:0] SEL_OPERAND = 2'd0;
  localparam logic [1:0] SEL_CTRL    = 2'd1;
  localparam logic [1:0] SEL_STATUS  = 2'd2;
  localparam logic [1:0] SEL_RESULT  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic                  r_awHeld;
  logic [1:0]            r_awSel;
  logic                  r_wHeld;
  logic [DW-1:0]         r_wData;
  logic [SW-1:0]         r_wStrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [DW-1:0]         r_rdata;

  logic [C_OP_WIDTH-1:0] r_operand;
  logic                  r_irqEn;
  logic                  r_busy;
  logic                  r_done;
  logic [ACC_W-1:0]      r_result;
  logic [C_OP_WIDTH-1:0] r_mcand;
  logic [C_OP_WIDTH-1:0] r_mplier;
  logic [ACC_W-1:0]      r_acc;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_awHs;
  logic                  w_wHs;
  logic                  w_arHs;
  logic                  w_doWrite;
  logic                  w_selOperand;
  logic                  w_opWriteErr;
  logic                  w_wrOperand;
  logic                  w_wrCtrl;
  logic                  w_startReq;
  logic                  w_clrDone;
  logic [DW-1:0]         w_byteMask;
  logic [C_OP_WIDTH-1:0] w_opMask;
  logic [C_OP_WIDTH-1:0] w_opNext;
  logic [DW-1:0]         w_rdMux;
  logic                  w_lastIter;
  logic                  w_load;
  logic                  w_step;
  logic                  w_finish;
  logic                  w_unused;

  // Readies are forced low while reset is held so nothing handshakes during reset.
  assign s00_axi_awready = ~s00_axi_areset & ~r_awHeld & ~r_bvalid;
  assign s00_axi_wready  = ~s00_axi_areset & ~r_wHeld & ~r_bvalid;
  assign s00_axi_arready = ~s00_axi_areset & ~r_rvalid;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = RESP_OKAY;
  assign irq             = r_done & r_irqEn;

  assign w_awHs    = s00_axi_awvalid & s00_axi_awready;
  assign w_wHs     = s00_axi_wvalid & s00_axi_wready;
  assign w_arHs    = s00_axi_arvalid & s00_axi_arready;
  assign w_doWrite = r_awHeld & r_wHeld;

  assign w_selOperand = (r_awSel == SEL_OPERAND);
  assign w_opWriteErr = w_selOperand & r_busy;
  assign w_wrOperand  = w_doWrite & w_selOperand & ~r_busy;
  assign w_wrCtrl     = w_doWrite & (r_awSel == SEL_CTRL) & r_wStrb[0];
  assign w_startReq   = w_wrCtrl & r_wData[0];
  assign w_clrDone    = w_doWrite & (r_awSel == SEL_STATUS) & r_wStrb[0] & r_wData[1];

  always_comb begin
    w_byteMask = '0;
    for (int i = 0; i < SW; i++) begin
      w_byteMask[i*8 +: 8] = {8{r_wStrb[i]}};
    end
  end

  assign w_opMask = w_byteMask[C_OP_WIDTH-1:0];
  assign w_opNext = (r_operand & ~w_opMask) | (r_wData[C_OP_WIDTH-1:0] & w_opMask);

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr,
                      r_wData, w_byteMask};

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_awHeld <= 1'b0;
      r_awSel  <= 2'd0;
      r_wHeld  <= 1'b0;
      r_wData  <= '0;
      r_wStrb  <= '0;
    end else if (w_doWrite) begin
      r_awHeld <= 1'b0;
      r_wHeld  <= 1'b0;
    end else begin
      if (w_awHs) begin
        r_awHeld <= 1'b1;
        r_awSel  <= s00_axi_awaddr[3:2];
      end
      if (w_wHs) begin
        r_wHeld <= 1'b1;
        r_wData <= s00_axi_wdata;
        r_wStrb <= s00_axi_wstrb;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_doWrite) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_opWriteErr ? RESP_SLVERR : RESP_OKAY;
    end else if (r_bvalid && s00_axi_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_operand <= '0;
      r_irqEn   <= 1'b0;
    end else begin
      if (w_wrOperand) r_operand <= w_opNext;
      if (w_wrCtrl)    r_irqEn   <= r_wData[1];
    end
  end

  assign w_lastIter = (r_cnt == CNT_W'(C_OP_WIDTH - 1));

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) r_state <= S_IDLE;
    else                r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_startReq) w_nextState = S_CALC;
      S_CALC:  if (w_lastIter) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // START arriving outside IDLE (CALC or the single DONE cycle) is dropped.
  always_comb begin
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE:  w_load   = w_startReq;
      S_CALC:  w_step   = 1'b1;
      S_DONE:  w_finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_result <= '0;
    end else if (w_load) begin
      r_mcand  <= r_operand;
      r_mplier <= r_operand;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (w_step) begin
      if (r_mplier[0]) r_acc <= r_acc + (ACC_W'(r_mcand) << r_cnt);
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end else if (w_finish) begin
      r_result <= r_acc;
      r_busy   <= 1'b0;
    end
  end

  // Hardware completion outranks a software W1C landing in the same cycle.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset)             r_done <= 1'b0;
    else if (w_finish)              r_done <= 1'b1;
    else if (w_load || w_clrDone)   r_done <= 1'b0;
  end

  always_comb begin
    w_rdMux = '0;
    case (s00_axi_araddr[3:2])
      SEL_OPERAND: w_rdMux = DW'(r_operand);
      SEL_CTRL:    w_rdMux = {{(DW-2){1'b0}}, r_irqEn, 1'b0};
      SEL_STATUS:  w_rdMux = {{(DW-2){1'b0}}, r_done, r_busy};
      SEL_RESULT:  w_rdMux = DW'(r_result);
      default:     w_rdMux = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_arHs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdMux;
    end else if (r_rvalid && s00_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sqr_axil_slave.sv
// Scenario testbench for sqr_axil_slave; expected read data is queued when a read is issued
// and compared when the R beat arrives.
module tb_sqr_axil_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        irq;

  int          vecCount = 0;
  int          missCount = 0;
  int          cycle = 0;
  logic [31:0] expQ[$];
  logic [15:0] modelOperand;
  logic [31:0] modelResult;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  sqr_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .C_OP_WIDTH(16)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .irq            (irq)
  );

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic reportTimeout(input string what);
    vecCount++;
    missCount++;
    $display("[TB] FAIL %s: actual=no response required=response within bound", what);
  endtask

  task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awDelay, input int wDelay, input int bDelay,
                          output logic [1:0] resp, output int bCycle, output int bHigh,
                          output logic readyLeak, output logic bAfter);
    int n;
    fork
      begin
        int k;
        k = 0;
        repeat (awDelay) stepCycle();
        awaddr  = addr;
        awvalid = 1'b1;
        while (!awready && k < 50) begin stepCycle(); k++; end
        if (k >= 50) reportTimeout("aw_handshake");
        stepCycle();
        awvalid = 1'b0;
      end
      begin
        int k;
        k = 0;
        repeat (wDelay) stepCycle();
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        while (!wready && k < 50) begin stepCycle(); k++; end
        if (k >= 50) reportTimeout("w_handshake");
        stepCycle();
        wvalid = 1'b0;
      end
    join
    n = 0;
    while (!bvalid && n < 50) begin stepCycle(); n++; end
    if (n >= 50) reportTimeout("b_valid");
    bCycle    = cycle;
    resp      = bresp;
    bHigh     = 0;
    readyLeak = 1'b0;
    repeat (bDelay) begin
      if (bvalid) bHigh++;
      readyLeak = readyLeak | awready | wready;
      stepCycle();
    end
    bready = 1'b1;
    if (bvalid) bHigh++;
    readyLeak = readyLeak | awready | wready;
    stepCycle();
    bready = 1'b0;
    bAfter = bvalid;
  endtask

  task automatic axiRead(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    araddr  = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin stepCycle(); n++; end
    if (n >= 50) reportTimeout("ar_handshake");
    stepCycle();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin stepCycle(); n++; end
    if (n >= 50) reportTimeout("r_valid");
    data   = rdata;
    resp   = rresp;
    rready = 1'b1;
    stepCycle();
    rready = 1'b0;
  endtask

  task automatic waitIrq(output int seenCycle);
    int n;
    n = 0;
    while (!irq && n < 100) begin stepCycle(); n++; end
    if (n >= 100) reportTimeout("irq_rise");
    seenCycle = cycle;
  endtask

  task automatic test_reset;
    logic [31:0] got, exp;
    logic [1:0]  resp;
    logic [5:0]  obs;
    logic [3:0]  a;
    rst = 1'b1;
    repeat (3) stepCycle();
    obs = {awready, wready, arready, bvalid, rvalid, irq};
    vecCount++;
    if (obs !== 6'b0) begin
      missCount++;
      $display("[TB] FAIL reset_outputs: got=%b expected=%b", obs, 6'b0);
    end
    rst = 1'b0;
    stepCycle();
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      expQ.push_back(32'h0);
      axiRead(a, got, resp);
      exp = expQ.pop_front();
      vecCount++;
      if ({resp, got} !== {2'b00, exp}) begin
        missCount++;
        $display("[TB] FAIL reset_read_%h: got resp=%b data=%h expected resp=00 data=%h", a, resp, got, exp);
      end
    end
    vecCount++;
    if (irq !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_irq: got=%b expected=0", irq);
    end
    modelOperand = 16'h0;
    modelResult  = 32'h0;
  endtask

  task automatic test_write_order;
    logic [31:0] got, exp;
    logic [1:0]  resp;
    int          bc, bh;
    logic        leak, ba;
    axiWrite(4'h0, 32'h0000_00AB, 4'hF, 0, 3, 3, resp, bc, bh, leak, ba);
    modelOperand = 16'h00AB;
    vecCount++;
    if ({resp, leak, ba} !== 4'b0000 || bh !== 4) begin
      missCount++;
      $display("[TB] FAIL aw_first_b: got resp=%b leak=%b after=%b high=%0d expected resp=00 leak=0 after=0 high=4",
               resp, leak, ba, bh);
    end
    expQ.push_back(32'(modelOperand));
    axiRead(4'h0, got, resp);
    exp = expQ.pop_front();
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL aw_first_readback: got=%h expected=%h", got, exp);
    end
    axiWrite(4'h0, 32'h0000_1234, 4'hF, 3, 0, 0, resp, bc, bh, leak, ba);
    modelOperand = 16'h1234;
    vecCount++;
    if ({resp, leak, ba} !== 4'b0000 || bh !== 1) begin
      missCount++;
      $display("[TB] FAIL w_first_b: got resp=%b leak=%b after=%b high=%0d expected resp=00 leak=0 after=0 high=1",
               resp, leak, ba, bh);
    end
    expQ.push_back(32'(modelOperand));
    axiRead(4'h0, got, resp);
    exp = expQ.pop_front();
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL w_first_readback: got=%h expected=%h", got, exp);
    end
  endtask

  task automatic test_square;
    logic [31:0] got, exp;
    logic [1:0]  resp;
    int          bc, bh, irqCycle;
    logic        leak, ba;
    axiWrite(4'h0, 32'h0000_FFFF, 4'hF, 0, 0, 0, resp, bc, bh, leak, ba);
    modelOperand = 16'hFFFF;
    axiWrite(4'h4, 32'h0000_0003, 4'hF, 0, 0, 0, resp, bc, bh, leak, ba);
    expQ.push_back(32'h0000_0001);
    axiRead(4'h8, got, resp);
    exp = expQ.pop_front();
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL status_busy: got=%h expected=%h", got, exp);
    end
    waitIrq(irqCycle);
    vecCount++;
    if (irqCycle - bc !== 17) begin
      missCount++;
      $display("[TB] FAIL busy_latency: got=%0d expected=17", irqCycle - bc);
    end
    modelResult = 32'(modelOperand) * 32'(modelOperand);
    expQ.push_back(modelResult);
    axiRead(4'hC, got, resp);
    exp = expQ.pop_front();
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL result_ffff: got=%h expected=%h", got, exp);
    end
    expQ.push_back(32'h0000_0002);
    axiRead(4'h8, got, resp);
    exp = expQ.pop_front();
    vecCount++;
    if ({irq, got} !== {1'b1, exp}) begin
      missCount++;
      $display("[TB] FAIL status_done: got irq=%b status=%h expected irq=1 status=%h", irq, got, exp);
    end
    axiWrite(4'h8, 32'h0000_0002, 4'hF, 0, 0, 0, resp, bc, bh, leak, ba);
    expQ.push_back(32'h0000_0000);
    axiRead(4'h8, got, resp);
    exp = expQ.pop_front();
    vecCount++;
    if ({irq, got} !== {1'b0, exp}) begin
      missCount++;
      $display("[TB] FAIL done_w1c: got irq=%b status=%h expected irq=0 status=%h", irq, got, exp);
    end
  endtask

  task automatic test_busy_errors;
    logic [31:0] got, exp;
    logic [1:0]  resp;
    int          bc, bcStart, bh, irqCycle;
    logic        leak, ba;
    axiWrite(4'h0, 32'h0000_00C8, 4'hF, 0, 0, 0, resp, bc, bh, leak, ba);
    modelOperand = 16'h00C8;
    axiWrite(4'h4, 32'h0000_0003, 4'hF, 0, 0, 0, resp, bcStart, bh, leak, ba);
    axiWrite(4'h0, 32'h0000_0005, 4'hF, 0, 0, 0, resp, bc, bh, leak, ba);
    vecCount++;
    if (resp !== 2'b10) begin
      missCount++;
      $display("[TB] FAIL busy_operand_resp: got=%b expected=10", resp);
    end
    axiWrite(4'h4, 32'h0000_0003, 4'hF, 0, 0, 0, resp, bc, bh, leak, ba);
    vecCount++;
    if (resp !== 2'b00) begin
      missCount++;
      $display("[TB] FAIL busy_start_resp: got=%b expected=00", resp);
    end
    expQ.push_back(32'(modelOperand));
    axiRead(4'h0, got, resp);
    exp = expQ.pop_front();
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL busy_operand_kept: got=%h expected=%h", got, exp);
    end
    waitIrq(irqCycle);
    vecCount++;
    if (irqCycle - bcStart !== 17) begin
      missCount++;
      $display("[TB] FAIL restart_ignored: got latency=%0d expected=17", irqCycle - bcStart);
    end
    modelResult = 32'(modelOperand) * 32'(modelOperand);
    expQ.push_back(modelResult);
    axiRead(4'hC, got, resp);
    exp = expQ.pop_front();
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL result_c8: got=%h expected=%h", got, exp);
    end
  endtask

  task automatic test_read_stall_strobes;
    logic [31:0] got, exp, first;
    logic [1:0]  resp;
    int          n, bc, bh;
    logic        leak, ba;
    expQ.push_back(modelResult);
    araddr  = 4'hC;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin stepCycle(); n++; end
    if (n >= 50) reportTimeout("stall_ar");
    stepCycle();
    n = 0;
    while (!rvalid && n < 50) begin stepCycle(); n++; end
    if (n >= 50) reportTimeout("stall_r");
    first = rdata;
    for (int i = 0; i < 10; i++) begin
      vecCount++;
      if ({rvalid, arready, rdata} !== {1'b1, 1'b0, expQ[0]}) begin
        missCount++;
        $display("[TB] FAIL stall_hold_%0d: got rvalid=%b arready=%b rdata=%h expected rvalid=1 arready=0 rdata=%h",
                 i, rvalid, arready, rdata, expQ[0]);
      end
      stepCycle();
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    stepCycle();
    rready = 1'b0;
    exp = expQ.pop_front();
    vecCount++;
    if ({rvalid, first} !== {1'b0, exp}) begin
      missCount++;
      $display("[TB] FAIL stall_beat: got rvalid=%b data=%h expected rvalid=0 data=%h", rvalid, first, exp);
    end
    axiWrite(4'h0, 32'h0000_0003, 4'h2, 0, 0, 0, resp, bc, bh, leak, ba);
    modelOperand = (modelOperand & 16'h00FF) | (16'h0003 & 16'hFF00);
    expQ.push_back(32'(modelOperand));
    axiRead(4'h0, got, resp);
    exp = expQ.pop_front();
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL strobe_upper: got=%h expected=%h", got, exp);
    end
    axiWrite(4'h0, 32'h0000_1234, 4'h1, 0, 0, 0, resp, bc, bh, leak, ba);
    modelOperand = (modelOperand & 16'hFF00) | (16'h1234 & 16'h00FF);
    expQ.push_back(32'(modelOperand));
    axiRead(4'h0, got, resp);
    exp = expQ.pop_front();
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL strobe_lower: got=%h expected=%h", got, exp);
    end
  endtask

  task automatic test_reset_midcalc;
    logic [31:0] got, exp;
    logic [1:0]  resp;
    logic [5:0]  obs;
    logic [3:0]  a;
    int          n, bc, bh, irqCycle;
    logic        leak, ba;
    axiWrite(4'h4, 32'h0000_0001, 4'hF, 0, 0, 0, resp, bc, bh, leak, ba);
    n = 0;
    while (cycle < bc + 5 && n < 50) begin stepCycle(); n++; end
    rst = 1'b1;
    #1;
    obs = {awready, wready, arready, bvalid, rvalid, irq};
    vecCount++;
    if (obs !== 6'b0) begin
      missCount++;
      $display("[TB] FAIL midcalc_reset_outputs: got=%b expected=%b", obs, 6'b0);
    end
    stepCycle();
    stepCycle();
    rst = 1'b0;
    stepCycle();
    modelOperand = 16'h0;
    modelResult  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      expQ.push_back(32'h0);
      axiRead(a, got, resp);
      exp = expQ.pop_front();
      vecCount++;
      if (got !== exp) begin
        missCount++;
        $display("[TB] FAIL midcalc_read_%h: got=%h expected=%h", a, got, exp);
      end
    end
    axiWrite(4'h0, 32'h0000_0003, 4'hF, 0, 0, 0, resp, bc, bh, leak, ba);
    modelOperand = 16'h0003;
    axiWrite(4'h4, 32'h0000_0003, 4'hF, 0, 0, 0, resp, bc, bh, leak, ba);
    waitIrq(irqCycle);
    modelResult = 32'(modelOperand) * 32'(modelOperand);
    expQ.push_back(modelResult);
    axiRead(4'hC, got, resp);
    exp = expQ.pop_front();
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL post_reset_result: got=%h expected=%h", got, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    awaddr  = 4'h0;
    awprot  = 3'b000;
    awvalid = 1'b0;
    wdata   = 32'h0;
    wstrb   = 4'h0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    araddr  = 4'h0;
    arprot  = 3'b000;
    arvalid = 1'b0;
    rready  = 1'b0;
    $display("[TB] starting sqr_axil_slave scenarios");
    test_reset();
    test_write_order();
    test_square();
    test_busy_errors();
    test_read_stall_strobes();
    test_reset_midcalc();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
